sprite_scan_gen: RTL and testbench

- Parametrised pixel-scan generator for the VGA plotting path.
- Walks a rectangle row-major, either the full screen or a sprite box anchored at (xInit, yInit), and emits one pixel coordinate per accepted transfer.
- Each pixel carries a linear sprite-memory address, so the colour mux can index the selected sprite ROM directly.
- Replaces the fixed 160x120 and 40x40 counters. Adds a valid/ready handshake, screen clipping, a start/done protocol and programmable extents.

---
 rtl/sprite_scan_gen.sv | 154 +++++++++++++++
 tb/tb_sprite_scan_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : sprite_scan_gen
// Summary  : Row-major pixel scan of the full screen or an anchored sprite box,
//            with a valid/ready pixel handshake and a start/done protocol.
//            Screen clipping is built in when SPRITE_SCAN_CLIP_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module sprite_scan_gen #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SPRITE_W = 40,
  parameter int SPRITE_H = 40,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [X_W-1:0]    xInit,
  input  logic [Y_W-1:0]    yInit,
  input  logic              ready,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              plot,
  output logic              busy,
  output logic              screenDone
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [X_W-1:0] c_fullLastCol = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] c_fullLastRow = Y_W'(SCREEN_H - 1);
  localparam logic [X_W-1:0] c_sprLastCol  = X_W'(SPRITE_W - 1);
  localparam logic [Y_W-1:0] c_sprLastRow  = Y_W'(SPRITE_H - 1);

  state_t            r_state;
  state_t            w_stateNext;
  logic [X_W-1:0]    r_origX;
  logic [Y_W-1:0]    r_origY;
  logic [X_W-1:0]    r_lastCol;
  logic [Y_W-1:0]    r_lastRow;
  logic [X_W-1:0]    r_col;
  logic [Y_W-1:0]    r_row;
  logic [ADDR_W-1:0] r_addr;

  logic              w_onScreen;
  logic              w_inScan;
  logic              w_plot;
  logic              w_step;
  logic              w_atLastCol;
  logic              w_atLastRow;
  logic              w_lastPixel;
  logic              w_accept;

`ifdef SPRITE_SCAN_CLIP_EN
  // Full-precision sums so a coordinate that overflows its port width is
  // treated as off-screen rather than wrapping back onto the display.
  localparam logic [X_W:0] c_screenW = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] c_screenH = (Y_W+1)'(SCREEN_H);

  logic [X_W:0] w_sumX;
  logic [Y_W:0] w_sumY;

  assign w_sumX     = {1'b0, r_origX} + {1'b0, r_col};
  assign w_sumY     = {1'b0, r_origY} + {1'b0, r_row};
  assign w_onScreen = (w_sumX < c_screenW) && (w_sumY < c_screenH);
`else
  assign w_onScreen = 1'b1;
`endif

  assign w_inScan    = (r_state == S_SCAN);
  assign w_plot      = w_inScan && w_onScreen;
  // Off-screen pixels never wait for ready, so they drain one per cycle.
  assign w_step      = w_inScan && (!w_plot || ready);
  assign w_atLastCol = (r_col == r_lastCol);
  assign w_atLastRow = (r_row == r_lastRow);
  assign w_lastPixel = w_atLastCol && w_atLastRow;
  assign w_accept    = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_origX   <= '0;
      r_origY   <= '0;
      r_lastCol <= '0;
      r_lastRow <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_addr    <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_origX   <= mode ? '0 : xInit;
        r_origY   <= mode ? '0 : yInit;
        r_lastCol <= mode ? c_fullLastCol : c_sprLastCol;
        r_lastRow <= mode ? c_fullLastRow : c_sprLastRow;
        r_col     <= '0;
        r_row     <= '0;
        r_addr    <= '0;
      end else if (w_step && !w_lastPixel) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (w_atLastCol) begin
          r_col <= '0;
          r_row <= r_row + Y_W'(1);
        end else begin
          r_col <= r_col + X_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    busy        = 1'b0;
    screenDone  = 1'b0;
    plot        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_stateNext = S_SCAN;
        end
      end
      S_SCAN: begin
        busy = 1'b1;
        plot = w_plot;
        if (w_step && w_lastPixel) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        screenDone  = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Coordinates wrap at the port width; clipping (when built) hides the wrap.
  assign x    = r_origX + r_col;
  assign y    = r_origY + r_row;
  assign addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_sprite_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_scan_gen
// Summary  : Scoreboard bench for sprite_scan_gen; expected pixels are queued
//            at each start and popped on every accepted transfer.
// Revision : 1.0  initial release
// ============================================================================
module tb_sprite_scan_gen;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE_W = 40;
  localparam int SPRITE_H = 40;
  localparam int ADDR_W   = 15;
  localparam int PIX_W    = X_W + Y_W + ADDR_W;

  logic              clk    = 1'b0;
  logic              reset  = 1'b0;
  logic              start  = 1'b0;
  logic              mode   = 1'b0;
  logic              ready  = 1'b0;
  logic [X_W-1:0]    xInit  = '0;
  logic [Y_W-1:0]    yInit  = '0;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] addr;
  logic              plot;
  logic              busy;
  logic              screenDone;

  sprite_scan_gen #(
    .X_W(X_W), .Y_W(Y_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
    .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .xInit(xInit), .yInit(yInit), .ready(ready),
    .x(x), .y(y), .addr(addr), .plot(plot), .busy(busy),
    .screenDone(screenDone)
  );

  always #5 clk = ~clk;

  logic [PIX_W-1:0] expQ[$];
  logic [PIX_W-1:0] monExp;
  logic [PIX_W-1:0] held;
  bit               stallValid = 1'b0;
  int checks = 0;
  int passes = 0;
  int accepted = 0;
  int expCount = 0;
  int stallCycles = 0;
  int scanCycles = 0;
  int lastAcceptCyc = 0;
  int doneCyc = 0;
  int rdyMode = 0;
  int cyc = 0;

  // Monitor: pops the scoreboard on each transfer and checks stall stability.
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      stallValid = 1'b0;
    end else begin
      if (busy === 1'b1) scanCycles++;
      if (stallValid) begin
        checks++;
        if (plot !== 1'b1 || {x, y, addr} !== held)
          $display("FAIL stall_hold: got plot=%b x=%0d y=%0d addr=%0d, required plot=1 x=%0d y=%0d addr=%0d",
                   plot, x, y, addr, held[PIX_W-1 -: X_W], held[ADDR_W+Y_W-1 -: Y_W], held[ADDR_W-1:0]);
        else passes++;
      end
      stallValid = 1'b0;
      if (plot === 1'b1) begin
        if (ready === 1'b1) begin
          checks++;
          if (expQ.size() == 0) begin
            $display("FAIL pixel_extra: got x=%0d y=%0d addr=%0d, required no pixel", x, y, addr);
          end else begin
            monExp = expQ.pop_front();
            if ({x, y, addr} !== monExp)
              $display("FAIL pixel: got x=%0d y=%0d addr=%0d, required x=%0d y=%0d addr=%0d",
                       x, y, addr, monExp[PIX_W-1 -: X_W], monExp[ADDR_W+Y_W-1 -: Y_W], monExp[ADDR_W-1:0]);
            else passes++;
          end
          accepted++;
          lastAcceptCyc = cyc;
        end else begin
          held = {x, y, addr};
          stallValid = 1'b1;
          stallCycles++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    case (rdyMode)
      0:       ready = 1'b1;
      1:       ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: ready = 1'($urandom_range(0, 1));
    endcase
    cyc++;
  endtask

  task automatic push_expected(input logic m, input logic [X_W-1:0] xi, input logic [Y_W-1:0] yi);
    int w, h, ox, oy, a, sx, sy;
    bit keep;
    w = m ? SCREEN_W : SPRITE_W;
    h = m ? SCREEN_H : SPRITE_H;
    ox = m ? 0 : int'(xi);
    oy = m ? 0 : int'(yi);
    a = 0;
    expCount = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        sx = ox + c;
        sy = oy + r;
        keep = 1'b1;
`ifdef SPRITE_SCAN_CLIP_EN
        keep = (sx < SCREEN_W) && (sy < SCREEN_H);
`endif
        if (keep) begin
          expQ.push_back({X_W'(sx), Y_W'(sy), ADDR_W'(a)});
          expCount++;
        end
        a++;
      end
    end
  endtask

  task automatic start_scan(input logic m, input logic [X_W-1:0] xi, input logic [Y_W-1:0] yi);
    tick();
    mode = m;
    xInit = xi;
    yInit = yi;
    start = 1'b1;
    expQ.delete();
    push_expected(m, xi, yi);
    accepted = 0;
    stallCycles = 0;
    scanCycles = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      #2;
      if (screenDone === 1'b1) begin
        seen = 1'b1;
        doneCyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({x, y, addr, plot, busy, screenDone} !== '0)
      $display("FAIL reset_outputs: got x=%0d y=%0d addr=%0d plot=%b busy=%b done=%b, required all 0",
               x, y, addr, plot, busy, screenDone);
    else passes++;
    tick();
    tick();
    reset = 1'b1;
    tick();
    #2;
    checks++;
    if (busy !== 1'b0 || plot !== 1'b0) $display("FAIL idle_after_reset: got busy=%b plot=%b, required 0 0", busy, plot);
    else passes++;
  endtask

  task automatic test_full_screen();
    bit seen;
    rdyMode = 0;
    start_scan(1'b1, 8'd55, 7'd9);
    wait_done(SCREEN_W * SCREEN_H + 100, seen);
    checks++; if (!seen) $display("FAIL full_done: got no screenDone, required pulse"); else passes++;
    checks++; if (accepted !== SCREEN_W * SCREEN_H) $display("FAIL full_count: got %0d required %0d", accepted, SCREEN_W * SCREEN_H); else passes++;
    checks++; if (scanCycles !== SCREEN_W * SCREEN_H) $display("FAIL full_cycles: got %0d required %0d", scanCycles, SCREEN_W * SCREEN_H); else passes++;
    checks++; if (doneCyc - lastAcceptCyc !== 1) $display("FAIL full_done_latency: got %0d required 1", doneCyc - lastAcceptCyc); else passes++;
    checks++; if (addr !== ADDR_W'(19199) || busy !== 1'b0 || plot !== 1'b0) $display("FAIL full_end: got addr=%0d busy=%b plot=%b required 19199 0 0", addr, busy, plot); else passes++;
    tick();
    #2;
    checks++; if (screenDone !== 1'b0) $display("FAIL full_done_pulse: got %b required 0", screenDone); else passes++;
  endtask

  task automatic test_sprite();
    bit seen;
    rdyMode = 0;
    start_scan(1'b0, 8'd36, 7'd30);
    wait_done(4000, seen);
    checks++; if (!seen) $display("FAIL sprite_done: got no screenDone, required pulse"); else passes++;
    checks++; if (accepted !== 1600 || expQ.size() != 0) $display("FAIL sprite_count: got %0d (left %0d) required 1600", accepted, expQ.size()); else passes++;
    checks++; if (addr !== ADDR_W'(1599)) $display("FAIL sprite_addr_end: got %0d required 1599", addr); else passes++;
    checks++; if (doneCyc - lastAcceptCyc !== 1) $display("FAIL sprite_done_latency: got %0d required 1", doneCyc - lastAcceptCyc); else passes++;
  endtask

  task automatic test_backpressure();
    bit seen;
    rdyMode = 1;
    start_scan(1'b0, 8'd36, 7'd30);
    wait_done(8000, seen);
    checks++; if (!seen) $display("FAIL bp_done: got no screenDone, required pulse"); else passes++;
    checks++; if (accepted !== expCount || expQ.size() != 0) $display("FAIL bp_count: got %0d required %0d", accepted, expCount); else passes++;
    checks++; if (scanCycles !== 1600 + stallCycles) $display("FAIL bp_cycles: got %0d required %0d", scanCycles, 1600 + stallCycles); else passes++;
    checks++; if (stallCycles < 1000) $display("FAIL bp_stalls: got %0d required >=1000", stallCycles); else passes++;
    rdyMode = 0;
  endtask

  task automatic test_clip();
    bit seen;
    rdyMode = 0;
    start_scan(1'b0, 8'd140, 7'd100);
    wait_done(4000, seen);
    checks++; if (!seen) $display("FAIL clip_done: got no screenDone, required pulse"); else passes++;
`ifdef SPRITE_SCAN_CLIP_EN
    checks++; if (accepted !== 400) $display("FAIL clip_count: got %0d required 400", accepted); else passes++;
`else
    checks++; if (accepted !== 1600) $display("FAIL clip_count: got %0d required 1600", accepted); else passes++;
`endif
    checks++; if (expQ.size() != 0) $display("FAIL clip_left: got %0d pixels unseen required 0", expQ.size()); else passes++;
    checks++; if (scanCycles !== 1600) $display("FAIL clip_cycles: got %0d required 1600", scanCycles); else passes++;
    checks++; if (addr !== ADDR_W'(1599)) $display("FAIL clip_addr_end: got %0d required 1599", addr); else passes++;
  endtask

  task automatic test_ignore_start();
    bit seen;
    rdyMode = 2;
    start_scan(1'b0, 8'd10, 7'd20);
    seen = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      tick();
      if (i == 50) begin start = 1'b1; mode = 1'b1; xInit = 8'd0; yInit = 7'd0; end
      if (i == 54) start = 1'b0;
      #2;
      if (screenDone === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) $display("FAIL ign_done: got no screenDone, required pulse"); else passes++;
    checks++; if (accepted !== 1600 || expQ.size() != 0) $display("FAIL ign_count: got %0d (left %0d) required 1600", accepted, expQ.size()); else passes++;
    start = 1'b1;
    xInit = 8'd77;
    tick();
    start = 1'b0;
    #2;
    checks++; if (busy !== 1'b0 || plot !== 1'b0) $display("FAIL ign_done_start: got busy=%b plot=%b required 0 0", busy, plot); else passes++;
    tick();
    tick();
    #2;
    checks++; if (busy !== 1'b0) $display("FAIL ign_stays_idle: got busy=%b required 0", busy); else passes++;
    start_scan(1'b0, 8'd100, 7'd5);
    wait_done(8000, seen);
    checks++; if (!seen || accepted !== 1600 || expQ.size() != 0) $display("FAIL ign_fresh: got done=%b count=%0d required 1 1600", seen, accepted); else passes++;
    rdyMode = 0;
  endtask

  task automatic test_reset_abort();
    bit seen;
    rdyMode = 0;
    start_scan(1'b0, 8'd36, 7'd30);
    for (int i = 0; i < 2000; i++) begin
      tick();
      #2;
      if (accepted >= 500) break;
    end
    checks++; if (accepted < 500) $display("FAIL abort_reach: got %0d pixels required 500", accepted); else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if ({x, y, addr, plot, busy, screenDone} !== '0)
      $display("FAIL abort_async: got x=%0d y=%0d addr=%0d plot=%b busy=%b done=%b, required all 0",
               x, y, addr, plot, busy, screenDone);
    else passes++;
    expQ.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      checks++; if (screenDone !== 1'b0 || busy !== 1'b0) $display("FAIL abort_no_done: got done=%b busy=%b required 0 0", screenDone, busy); else passes++;
    end
    tick();
    reset = 1'b1;
    start_scan(1'b0, 8'd36, 7'd30);
    wait_done(4000, seen);
    checks++; if (!seen || accepted !== 1600 || expQ.size() != 0) $display("FAIL abort_restart: got done=%b count=%0d required 1 1600", seen, accepted); else passes++;
    checks++; if (addr !== ADDR_W'(1599)) $display("FAIL abort_addr_end: got %0d required 1599", addr); else passes++;
  endtask

  initial begin
    test_reset();
    test_full_screen();
    test_sprite();
    test_backpressure();
    test_clip();
    test_ignore_start();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
